// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues req/ack reads for the current PC, loads the
// IF/ID register, parks one instruction in a skid buffer while decode stalls,
// and drops in-flight fetches on branch/jump flush.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_REQ   | normal fetch; request issued for pc when aligned
// S_DROP  | a killed request is still outstanding; its data is discarded
// S_STALL | a fetched instruction is parked in the skid buffer
module if_fetch_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_hold,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        flush,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DROP  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus4;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_addr_q;
    logic [7:0]  r_to_cnt;
    logic        r_fetch_err;
    // Fetching halts after a misaligned PC until a flush redirects it.
    logic        r_halt;

    logic        w_misaligned;
    logic        w_accept;
    logic        w_if_hold;
    logic        w_to_hit;

    assign w_misaligned = (pc[1:0] != 2'b00);
    assign w_if_hold    = r_if_valid && id_stall;

    // Next-state decode plus the memory request / PC hold outputs.
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        imem_addr   = pc;
        case (r_state)
            S_REQ:   imem_req = !w_misaligned && !r_halt;
            S_DROP: begin
                imem_req  = 1'b1;
                imem_addr = r_addr_q;
            end
            S_STALL: imem_req = 1'b0;
            default: imem_req = 1'b0;
        endcase

        w_accept = (r_state == S_REQ) && imem_req && imem_ack && !flush;
        pc_hold  = !w_accept;

        if (flush) begin
            // An unanswered request must still be drained before refetching.
            w_state_nxt = (imem_req && !imem_ack) ? S_DROP : S_REQ;
        end else begin
            case (r_state)
                S_REQ:   if (w_accept && w_if_hold) w_state_nxt = S_STALL;
                S_DROP:  if (imem_ack) w_state_nxt = S_REQ;
                S_STALL: if (!w_if_hold) w_state_nxt = S_REQ;
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_REQ;
        else     r_state <= w_state_nxt;
    end

    // IF/ID register and skid buffer, in flush > hold > unpark > accept order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
        end else if (flush) begin
            r_if_valid    <= 1'b0;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
        end else if (w_if_hold) begin
            if (w_accept) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= pc;
            end
        end else if (r_state == S_STALL) begin
            r_if_valid    <= 1'b1;
            r_if_instr    <= r_skid_instr;
            r_if_pc       <= r_skid_pc;
            r_if_pc_plus4 <= r_skid_pc + 32'd4;
        end else if (w_accept) begin
            r_if_valid    <= 1'b1;
            r_if_instr    <= imem_rdata;
            r_if_pc       <= pc;
            r_if_pc_plus4 <= pc + 32'd4;
        end else begin
            r_if_valid    <= 1'b0;
        end
    end

    // Remember the address of the request in flight so a drop can keep it stable.
    always_ff @(posedge clk) begin
        if (rst)                    r_addr_q <= '0;
        else if (r_state == S_REQ)  r_addr_q <= pc;
    end

    assign w_to_hit = imem_req && !imem_ack && (r_to_cnt != 8'hFF) &&
                      ((r_to_cnt + 8'd1) == TO_LIM);

    // Saturating wait counter, sticky error flag and misalignment halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt    <= '0;
            r_fetch_err <= 1'b0;
            r_halt      <= 1'b0;
        end else begin
            if (imem_ack)
                r_to_cnt <= '0;
            else if (imem_req && (r_to_cnt != 8'hFF))
                r_to_cnt <= r_to_cnt + 8'd1;

            if (w_to_hit || ((r_state == S_REQ) && w_misaligned))
                r_fetch_err <= 1'b1;

            if (flush)
                r_halt <= 1'b0;
            else if ((r_state == S_REQ) && w_misaligned)
                r_halt <= 1'b1;
        end
    end

    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: per-cycle vector table for the handshake outputs,
// a scoreboard of fetched words checked as decode consumes them, and a
// hand-written timeout sequence.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fetch_err;

    always #5 clk = ~clk;

    if_fetch_stage #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_hold    (pc_hold),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_stall   (id_stall),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc_plus4(if_pc_plus4),
        .fetch_err  (fetch_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rd;
        logic        st;
        logic        fl;
        logic        pu;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_hold;
        logic        e_valid;
        logic [31:0] e_ifpc;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] p, input logic a, input logic [31:0] rd,
                       input logic st, input logic fl, input logic pu,
                       input logic e_req, input logic [31:0] e_addr, input logic e_hold,
                       input logic e_valid, input logic [31:0] e_ifpc, input logic e_err);
        vec_t v;
        v.pc = p;  v.ack = a;  v.rd = rd;  v.st = st;  v.fl = fl;  v.pu = pu;
        v.e_req = e_req;  v.e_addr = e_addr;  v.e_hold = e_hold;
        v.e_valid = e_valid;  v.e_ifpc = e_ifpc;  v.e_err = e_err;
        vt.push_back(v);
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then cross the edge.
    task automatic apply(input vec_t v, input int idx);
        pc         = v.pc;
        imem_ack   = v.ack;
        imem_rdata = v.rd;
        id_stall   = v.st;
        flush      = v.fl;
        if (v.pu) sb.push_back('{instr: v.rd, pc: v.pc});
        #1;
        chk($sformatf("v%0d_req",   idx), {31'd0, imem_req},  {31'd0, v.e_req});
        chk($sformatf("v%0d_addr",  idx), imem_addr,          v.e_addr);
        chk($sformatf("v%0d_hold",  idx), {31'd0, pc_hold},   {31'd0, v.e_hold});
        chk($sformatf("v%0d_valid", idx), {31'd0, if_valid},  {31'd0, v.e_valid});
        chk($sformatf("v%0d_err",   idx), {31'd0, fetch_err}, {31'd0, v.e_err});
        if (v.e_valid) chk($sformatf("v%0d_ifpc", idx), if_pc, v.e_ifpc);
        @(posedge clk);
        #1;
    endtask

    // Decode consumes IF/ID at the next edge when valid and not stalled.
    always @(negedge clk) begin
        if (mon_en && if_valid && !id_stall) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: got pc %08h, want no instruction", if_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", if_instr,    e.instr);
                chk("sb_pc",    if_pc,       e.pc);
                chk("sb_plus4", if_pc_plus4, e.pc + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   pc         ack rdata         st fl pu | req addr        hold vld ifpc      err
        add(32'h00, 0, 32'h0,        0, 0, 0,   1, 32'h00, 1, 0, 32'h0,  0);
        add(32'h00, 1, 32'h20080005, 0, 0, 1,   1, 32'h00, 0, 0, 32'h0,  0);
        add(32'h04, 1, 32'h20090003, 0, 0, 1,   1, 32'h04, 0, 1, 32'h00, 0);
        add(32'h08, 1, 32'h01095020, 0, 0, 1,   1, 32'h08, 0, 1, 32'h04, 0);
        add(32'h0C, 0, 32'h0,        0, 0, 0,   1, 32'h0C, 1, 1, 32'h08, 0);
        add(32'h0C, 0, 32'h0,        0, 0, 0,   1, 32'h0C, 1, 0, 32'h0,  0);
        add(32'h0C, 0, 32'h0,        0, 0, 0,   1, 32'h0C, 1, 0, 32'h0,  0);
        add(32'h0C, 1, 32'hAAAA000C, 0, 0, 1,   1, 32'h0C, 0, 0, 32'h0,  0);
        add(32'h10, 1, 32'hBBBB0010, 0, 0, 1,   1, 32'h10, 0, 1, 32'h0C, 0);
        add(32'h14, 0, 32'h0,        1, 0, 0,   1, 32'h14, 1, 1, 32'h10, 0);
        add(32'h14, 1, 32'hCCCC0014, 1, 0, 1,   1, 32'h14, 0, 1, 32'h10, 0);
        add(32'h18, 0, 32'h0,        1, 0, 0,   0, 32'h18, 1, 1, 32'h10, 0);
        add(32'h18, 0, 32'h0,        0, 0, 0,   0, 32'h18, 1, 1, 32'h10, 0);
        add(32'h18, 1, 32'hDDDD0018, 0, 0, 1,   1, 32'h18, 0, 1, 32'h14, 0);
        add(32'h1C, 0, 32'h0,        0, 0, 0,   1, 32'h1C, 1, 1, 32'h18, 0);
        add(32'h1C, 0, 32'h0,        0, 1, 0,   1, 32'h1C, 1, 0, 32'h0,  0);
        add(32'h40, 0, 32'h0,        0, 0, 0,   1, 32'h1C, 1, 0, 32'h0,  0);
        add(32'h40, 1, 32'hDEADBEEF, 0, 0, 0,   1, 32'h1C, 1, 0, 32'h0,  0);
        add(32'h40, 1, 32'hEEEE0040, 0, 0, 1,   1, 32'h40, 0, 0, 32'h0,  0);
        add(32'h44, 0, 32'h0,        0, 0, 0,   1, 32'h44, 1, 1, 32'h40, 0);
        add(32'h44, 1, 32'h11112222, 0, 1, 0,   1, 32'h44, 1, 0, 32'h0,  0);
        add(32'h80, 1, 32'hFFFF0080, 0, 0, 1,   1, 32'h80, 0, 0, 32'h0,  0);
        add(32'h84, 0, 32'h0,        0, 0, 0,   1, 32'h84, 1, 1, 32'h80, 0);
        add(32'h84, 1, 32'h12345678, 0, 0, 1,   1, 32'h84, 0, 0, 32'h0,  0);
        add(32'h88, 0, 32'h0,        0, 0, 0,   1, 32'h88, 1, 1, 32'h84, 0);
        add(32'h06, 0, 32'h0,        0, 0, 0,   0, 32'h06, 1, 0, 32'h0,  0);
        add(32'h06, 0, 32'h0,        0, 1, 0,   0, 32'h06, 1, 0, 32'h0,  1);
        add(32'h100, 1, 32'h55556666, 0, 0, 1,  1, 32'h100, 0, 0, 32'h0, 1);
        add(32'h104, 0, 32'h0,       0, 0, 0,   1, 32'h104, 1, 1, 32'h100, 1);

        rst        = 1'b1;
        pc         = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        id_stall   = 1'b0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, if_valid},  32'd0);
        chk("rst_instr", if_instr,           32'd0);
        chk("rst_pc",    if_pc,              32'd0);
        chk("rst_plus4", if_pc_plus4,        32'd0);
        chk("rst_err",   {31'd0, fetch_err}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        foreach (vt[i]) apply(vt[i], i);

        chk("err_sticky", {31'd0, fetch_err}, 32'd1);

        // Timeout: TIMEOUT=8 wait cycles raise fetch_err with the request still up.
        rst      = 1'b1;
        pc       = 32'h0;
        imem_ack = 1'b0;
        flush    = 1'b0;
        id_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_clr_err", {31'd0, fetch_err}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("to%0d_req", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("to%0d_err", i), {31'd0, fetch_err}, (i < 8) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("to_rst_err", {31'd0, fetch_err}, 32'd0);
        rst = 1'b0;

        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
